// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one-entry completion buffer per FU, one result
// per cycle onto the register-file writeback bus, with stall lock and flush.
module wb_arbiter #(
  parameter int NREQ   = 5,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][REG_W-1:0]   req_rd,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              flush_mask,
  input  logic                         wb_stall,
  output logic                         wb_valid,
  output logic [REG_W-1:0]             wb_rd,
  output logic [DATA_W-1:0]            wb_data,
  output logic [IDX_W-1:0]             wb_fu,
  output logic [15:0]                  wb_count
);

  logic [NREQ-1:0]             buf_v_q, buf_v_d;
  logic [NREQ-1:0][REG_W-1:0]  buf_rd_q, buf_rd_d;
  logic [NREQ-1:0][DATA_W-1:0] buf_data_q, buf_data_d;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic                        lock_v_q, lock_v_d;
  logic [IDX_W-1:0]            lock_idx_q, lock_idx_d;
  logic [15:0]                 cnt_q, cnt_d;

  logic [NREQ-1:0]             cand;
  logic                        gnt_v;
  logic [IDX_W-1:0]            gnt;
  logic [IDX_W-1:0]            idx;
  logic                        xfer;

  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] a,
    input int               k
  );
    int s;
    s = int'(a) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDX_W'(s);
  endfunction

  // A stalled grant stays locked so the bus is held stable until it drains.
  always_comb begin
    cand  = buf_v_q & ~flush_mask;
    gnt_v = 1'b0;
    gnt   = '0;
    idx   = '0;
    if (lock_v_q && cand[lock_idx_q]) begin
      gnt_v = 1'b1;
      gnt   = lock_idx_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = wrap_add(rr_ptr_q, k);
        if (!gnt_v && cand[idx]) begin
          gnt_v = 1'b1;
          gnt   = idx;
        end
      end
    end
  end

  assign xfer     = gnt_v & ~wb_stall;
  assign wb_valid = gnt_v;
  assign wb_rd    = gnt_v ? buf_rd_q[gnt]   : '0;
  assign wb_data  = gnt_v ? buf_data_q[gnt] : '0;
  assign wb_fu    = gnt_v ? gnt             : '0;
  assign wb_count = cnt_q;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = ~flush_mask[i]
                   & (~buf_v_q[i] | (xfer & (gnt == IDX_W'(i))));
    end
  end

  // rd==0 results are accepted but dropped: nothing to write back.
  always_comb begin
    buf_v_d    = buf_v_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (flush_mask[i]) begin
        buf_v_d[i] = 1'b0;
      end else if (req_valid[i] && req_ready[i]) begin
        buf_v_d[i]    = |req_rd[i];
        buf_rd_d[i]   = req_rd[i];
        buf_data_d[i] = req_data[i];
      end else if (xfer && (gnt == IDX_W'(i))) begin
        buf_v_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_v_d   = 1'b0;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;
    if (xfer) begin
      rr_ptr_d = wrap_add(gnt, 1);
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (gnt_v) begin
      lock_v_d   = 1'b1;
      lock_idx_d = gnt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_v_q    <= '0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      rr_ptr_q   <= '0;
      lock_v_q   <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      buf_v_q    <= buf_v_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_v_q   <= lock_v_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-free
// array model of the buffers, round-robin pointer and stall lock.
module tb_wb_arbiter;
  localparam int N = 5;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0][4:0]    req_rd = '0;
  logic [N-1:0][31:0]   req_data = '0;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         flush_mask = '0;
  logic                 wb_stall = 1'b0;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic [31:0]          wb_data;
  logic [2:0]           wb_fu;
  logic [15:0]          wb_count;

  wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .flush_mask(flush_mask), .wb_stall(wb_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_fu(wb_fu), .wb_count(wb_count)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  bit          mbv[N];
  logic [4:0]  mrd[N];
  logic [31:0] mdat[N];
  int          mrr, mlidx, mcnt, mg;
  bit          mlock;
  logic [N-1:0] mready;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < N; i++) begin
      mbv[i] = 0; mrd[i] = '0; mdat[i] = '0;
    end
    mrr = 0; mlidx = 0; mcnt = 0; mlock = 0; mg = -1;
  endfunction

  function automatic int mgrant();
    if (mlock && mbv[mlidx] && !flush_mask[mlidx]) return mlidx;
    for (int k = 0; k < N; k++) begin
      int j = (mrr + k) % N;
      if (mbv[j] && !flush_mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_check();
    int  gi;
    bit  xf;
    mg = mgrant();
    gi = (mg < 0) ? 0 : mg;
    xf = (mg >= 0) && !wb_stall;
    for (int i = 0; i < N; i++)
      mready[i] = !flush_mask[i] && (!mbv[i] || (mg == i && xf));
    chk("wb_valid", wb_valid, (mg >= 0));
    chk("wb_rd", wb_rd, (mg >= 0) ? mrd[gi] : 5'd0);
    chk("wb_data", wb_data, (mg >= 0) ? mdat[gi] : 32'd0);
    chk("wb_fu", wb_fu, (mg >= 0) ? gi : 0);
    chk("req_ready", req_ready, mready);
    chk("wb_count", wb_count, mcnt);
  endtask

  function automatic void model_update();
    bit xf;
    xf = (mg >= 0) && !wb_stall;
    for (int i = 0; i < N; i++) begin
      if (flush_mask[i]) mbv[i] = 0;
      else if (req_valid[i] && mready[i]) begin
        mbv[i] = (req_rd[i] != 0);
        mrd[i] = req_rd[i];
        mdat[i] = req_data[i];
      end else if (xf && mg == i) mbv[i] = 0;
    end
    if (xf) begin
      mrr = (mg + 1) % N;
      mlock = 0;
      if (mcnt < 16'hFFFF) mcnt++;
    end else if (mg >= 0) begin
      mlock = 1;
      mlidx = mg;
    end else mlock = 0;
  endfunction

  task automatic idle();
    req_valid = '0; req_rd = '0; req_data = '0;
    flush_mask = '0; wb_stall = 1'b0;
  endtask

  task automatic cyc();
    #1;
    model_check();
  endtask

  task automatic adv();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle();
    mreset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  int exp_order[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    mreset();
    do_reset();

    // reset state
    cyc();
    chk("rst_valid", wb_valid, 1'b0);
    chk("rst_ready", req_ready, 5'b11111);
    chk("rst_count", wb_count, 16'd0);
    adv();

    // single FU2 result
    req_valid = 5'b00100; req_rd[2] = 5'd7; req_data[2] = 32'hDEAD;
    cyc();
    chk("t1_ready", req_ready[2], 1'b1);
    adv();
    idle();
    cyc();
    chk("t1_valid", wb_valid, 1'b1);
    chk("t1_rd", wb_rd, 5'd7);
    chk("t1_data", wb_data, 32'hDEAD);
    chk("t1_fu", wb_fu, 3'd2);
    adv();
    cyc();
    chk("t1_count", wb_count, 16'd1);
    adv();

    // round robin over FUs 0,1,3 with continuous reloads
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid = 5'b01011;
      for (int i = 0; i < N; i++) begin
        req_rd[i] = 5'(i + 1);
        req_data[i] = 32'h100 * c + i;
      end
      cyc();
      if (c > 0) begin
        chk("t2_order", wb_fu, exp_order[c-1]);
        chk("t2_ready", req_ready[exp_order[c-1]], 1'b1);
      end
      adv();
    end

    // stall lock with FU0 arriving mid-stall
    do_reset();
    req_valid = 5'b00010; req_rd[1] = 5'd9; req_data[1] = 32'h1111;
    cyc(); adv();
    idle();
    req_valid = 5'b00001; req_rd[0] = 5'd4; req_data[0] = 32'h2222;
    wb_stall = 1'b1;
    cyc();
    chk("t3_fu_s1", wb_fu, 3'd1);
    chk("t3_ready0", req_ready[0], 1'b1);
    adv();
    idle(); wb_stall = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cyc();
      chk("t3_fu_s", wb_fu, 3'd1);
      chk("t3_rd_s", wb_rd, 5'd9);
      chk("t3_data_s", wb_data, 32'h1111);
      adv();
    end
    wb_stall = 1'b0;
    cyc();
    chk("t3_fu_x", wb_fu, 3'd1);
    adv();
    cyc();
    chk("t3_fu_next", wb_fu, 3'd0);
    chk("t3_rd_next", wb_rd, 5'd4);
    adv();

    // flush of a locked FU4
    do_reset();
    req_valid = 5'b10000; req_rd[4] = 5'd12; req_data[4] = 32'h4444;
    cyc(); adv();
    idle(); wb_stall = 1'b1;
    cyc();
    chk("t4_lock_fu", wb_fu, 3'd4);
    adv();
    flush_mask = 5'b10000;
    cyc();
    chk("t4_valid_drop", wb_valid, 1'b0);
    adv();
    idle();
    cyc();
    chk("t4_valid_after", wb_valid, 1'b0);
    chk("t4_count", wb_count, 16'd0);
    adv();

    // rd==0 consumed, not written back
    do_reset();
    req_valid = 5'b01000; req_rd[3] = 5'd0; req_data[3] = 32'h5555;
    cyc();
    chk("t5_ready", req_ready[3], 1'b1);
    adv();
    idle();
    cyc();
    chk("t5_valid", wb_valid, 1'b0);
    chk("t5_count", wb_count, 16'd0);
    adv();

    // reset mid-stall with three buffers full
    do_reset();
    req_valid = 5'b00111;
    for (int i = 0; i < 3; i++) begin
      req_rd[i] = 5'(i + 20); req_data[i] = 32'hA0 + i;
    end
    cyc(); adv();
    idle(); wb_stall = 1'b1;
    cyc(); adv();
    cyc();
    chk("t6_pre_valid", wb_valid, 1'b1);
    RST = 1'b1;
    mreset();
    #1;
    chk("t6_valid", wb_valid, 1'b0);
    chk("t6_rd", wb_rd, 5'd0);
    chk("t6_data", wb_data, 32'd0);
    chk("t6_fu", wb_fu, 3'd0);
    chk("t6_count", wb_count, 16'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    idle();
    cyc();
    chk("t6_ready", req_ready, 5'b11111);
    adv();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_rd[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        req_data[i] = $urandom;
        flush_mask[i] = ($urandom_range(0, 9) == 0);
      end
      wb_stall = ($urandom_range(0, 3) == 0);
      cyc();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
